mul_seq_ctrl: RTL and testbench
===============================

// Module: mul_seq_ctrl
// PURPOSE
//  Sequencer wrapping the combinational mul32 array (ports a, b, lo, hi) for the RV32M MUL/MULH/MULHSU/MULHU ops.
//  Registers operands, feeds unsigned magnitudes to mul32 and waits MUL_CYCLES (a multicycle path).
//  Then sign-corrects the 64-bit product, selects lo/hi and returns the result over a valid/ready handshake.
//  Sits between the EX-stage issue logic and writeback; one op in flight.
// PARAMETERS
//  MUL_CYCLES  2  cycles the mul32 inputs are held stable before the product is sampled (legal range 1..15)
//  TAG_W       5  width of the opaque tag (destination register index) carried with each op
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  flush      in   1      kill any in-flight op and invalidate the reuse entry
//  req_valid  in   1      request present
//  req_ready  out  1      block can accept; 1 only in IDLE and !flush
//  req_op     in   2      00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0])
//  req_a      in   32     rs1 operand
//  req_b      in   32     rs2 operand
//  req_tag    in   TAG_W  returned unchanged on rsp_tag
//  rsp_valid  out  1      result present; held until rsp_ready
//  rsp_ready  in   1      consumer accepts the result
//  rsp_data   out  32     selected 32-bit result
//  rsp_tag    out  TAG_W  tag of the op in rsp_data
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rsp_valid=0, rsp_data=0, rsp_tag=0, busy=0, reuse_vld=0, counter=0; req_ready=0 while rst_n=0.
//  Sign class: a_sgn = op in {MULH,MULHSU}; b_sgn = (op==MULH).
//    MUL is computed in class MULHU (its lo result is class-independent).
//  Accept (req_valid & req_ready):
//    - latch tag and op; latch |a| and |b| per class into the mul32 input regs.
//    - neg = (a_sgn & a[31]) ^ (b_sgn & b[31]).
//    - |0x80000000| = 0x80000000 as unsigned; this needs no special case.
//  Reuse hit:
//    - condition: reuse_vld & a==last_a & b==last_b & (op==MUL | class==last_class).
//    - on a hit, go straight to DONE next cycle using the stored 64-bit result. Latency is 1.
//  Miss:
//    - IDLE -> CALC with counter=MUL_CYCLES-1.
//    - CALC decrements the counter. At counter==0, capture P = neg ? -{hi,lo} : {hi,lo} (64-bit two's complement).
//    - store P, a, b and class into the reuse entry; set reuse_vld; go to DONE.
//    - latency from accept edge to rsp_valid=1 is MUL_CYCLES+1 cycles.
//  DONE:
//    - rsp_valid=1; rsp_data = (op==MUL) ? P[31:0] : P[63:32].
//    - rsp_data and rsp_tag are stable while rsp_ready=0.
//    - rsp_valid & rsp_ready -> IDLE. There is no accept in the same cycle; the next accept is 1 cycle later.
//  flush:
//    - priority over everything except reset. Any state -> IDLE at the next edge.
//    - rsp_valid=0 at that edge, reuse_vld=0, and the pending result is discarded.
//    - a request presented during flush is not accepted (req_ready=0).
//  Reset mid-op: async return to reset values; no response is issued for the killed op.
//  Inputs req_a, req_b and req_op are don't-care when req_valid=0. mul32 inputs change only on an accept edge.
// STRUCTURE
//  Shared package mul_pkg:
//    - op encodings MUL_OP_*, state enum {IDLE, CALC, DONE}, sign-class encoding
//    - localparam XLEN=32, shared with the divider controller
//  Sub-module mul_sign_fix (combinational): operand abs-value on the input side and conditional 64-bit negate on the output side.
//  mul32 is instantiated once; the FSM, counter and reuse entry live in this file.
// TESTING
//  1. MUL a=7 b=6, rsp_ready=1 -> rsp_data=0x0000002A, rsp_tag=req_tag, rsp_valid exactly 3 cycles after accept (MUL_CYCLES=2).
//  2. MULH a=0xFFFFFFFF b=2 -> 0xFFFFFFFF. MULHU with the same operands -> 0x00000001 (class differs, full latency).
//  3. MULHSU a=0x80000000 b=0xFFFFFFFF -> 0x80000000. MULH a=b=0x80000000 -> 0x40000000.
//  4. MULH a=0x12345678 b=0x9ABCDEF0, then MUL with the same operands -> hit, rsp_valid 1 cycle after accept, rsp_data=0x242D2080.
//  5. Backpressure: rsp_ready=0 for 5 cycles in DONE -> rsp_valid/rsp_data/rsp_tag stable, req_ready=0, busy=1.
//     Then rsp_ready=1 -> IDLE next cycle, req_ready=1.
//  6. flush in the 1st CALC cycle -> IDLE next edge, no rsp_valid pulse, and the repeated op misses.
//     rst_n pulse in DONE -> rsp_valid drops asynchronously.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared multiplier definitions: op encodings, sequencer states and sign classes.
package mul_pkg;

  localparam int XLEN = 32;

  // RV32M funct3[1:0] encodings for the multiply group
  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // Which operands are treated as signed; MUL shares the MULHU class (00)
  typedef struct packed {
    logic a_sgn;
    logic b_sgn;
  } mul_cls_t;

  function automatic mul_cls_t mul_sign_class(input logic [1:0] op);
    mul_cls_t cls;
    cls.a_sgn = (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    cls.b_sgn = (op == MUL_OP_MULH);
    return cls;
  endfunction

endpackage

// File: rtl/mul32.sv
// Combinational 32x32 unsigned array multiplier; the sequencer treats it as a multicycle path.
module mul32
  import mul_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] hi
);

  logic [2*XLEN-1:0] prod;

  assign prod     = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
  assign {hi, lo} = prod;

endmodule

// File: rtl/mul_sign_fix.sv
// Sign handling around the unsigned multiplier: operand magnitudes in, conditional negate out.
module mul_sign_fix
  import mul_pkg::*;
(
  input  mul_cls_t          cls,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   a_mag,
  output logic [XLEN-1:0]   b_mag,
  output logic              neg,
  input  logic              prod_neg,
  input  logic [2*XLEN-1:0] prod,
  output logic [2*XLEN-1:0] prod_fixed
);

  logic a_neg;
  logic b_neg;

  // Magnitudes of the signed operands; 0x80000000 maps to itself as unsigned, which is correct
  always_comb begin
    a_neg      = cls.a_sgn & a[XLEN-1];
    b_neg      = cls.b_sgn & b[XLEN-1];
    a_mag      = a_neg ? (~a + 1'b1) : a;
    b_mag      = b_neg ? (~b + 1'b1) : b;
    neg        = a_neg ^ b_neg;
    prod_fixed = prod_neg ? (~prod + 1'b1) : prod;
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multiply sequencer: registers operands, waits out the mul32 multicycle path,
// sign-corrects the product and returns it over valid/ready, with a one-entry reuse cache.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

  mul_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   a_mag_q, a_mag_d;
  logic [XLEN-1:0]   b_mag_q, b_mag_d;
  logic [XLEN-1:0]   last_a_q, last_a_d;
  logic [XLEN-1:0]   last_b_q, last_b_d;
  mul_cls_t          last_cls_q, last_cls_d;
  logic [2*XLEN-1:0] reuse_p_q, reuse_p_d;
  logic              reuse_vld_q, reuse_vld_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;

  mul_cls_t          req_cls;
  logic [XLEN-1:0]   req_a_mag;
  logic [XLEN-1:0]   req_b_mag;
  logic              req_neg;
  logic [XLEN-1:0]   mul_lo;
  logic [XLEN-1:0]   mul_hi;
  logic [2*XLEN-1:0] prod_fixed;
  logic              accept;
  logic              reuse_hit;

  assign req_cls   = mul_sign_class(req_op);
  assign req_ready = rst_n & (state_q == IDLE) & ~flush;
  assign accept    = req_valid & req_ready;
  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;

  // The lo half is class-independent, so MUL may reuse an entry of any class
  assign reuse_hit = reuse_vld_q & (req_a == last_a_q) & (req_b == last_b_q) &
                     ((req_op == MUL_OP_MUL) | (req_cls == last_cls_q));

  mul_sign_fix u_sign_fix (
    .cls        (req_cls),
    .a          (req_a),
    .b          (req_b),
    .a_mag      (req_a_mag),
    .b_mag      (req_b_mag),
    .neg        (req_neg),
    .prod_neg   (neg_q),
    .prod       ({mul_hi, mul_lo}),
    .prod_fixed (prod_fixed)
  );

  mul32 u_mul32 (
    .a  (a_mag_q),
    .b  (b_mag_q),
    .lo (mul_lo),
    .hi (mul_hi)
  );

  // Next-state logic: accept/reuse in IDLE, countdown in CALC, handshake in DONE; flush overrides all
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    tag_d       = tag_q;
    neg_d       = neg_q;
    a_mag_d     = a_mag_q;
    b_mag_d     = b_mag_q;
    last_a_d    = last_a_q;
    last_b_d    = last_b_q;
    last_cls_d  = last_cls_q;
    reuse_p_d   = reuse_p_q;
    reuse_vld_d = reuse_vld_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = req_op;
          tag_d   = req_tag;
          neg_d   = req_neg;
          a_mag_d = req_a_mag;
          b_mag_d = req_b_mag;
          if (reuse_hit) begin
            state_d    = DONE;
            rsp_data_d = (req_op == MUL_OP_MUL) ? reuse_p_q[XLEN-1:0] : reuse_p_q[2*XLEN-1:XLEN];
            rsp_tag_d  = req_tag;
          end else begin
            state_d     = CALC;
            cnt_d       = CNT_INIT;
            last_a_d    = req_a;
            last_b_d    = req_b;
            last_cls_d  = req_cls;
            reuse_vld_d = 1'b0;
          end
        end
      end
      CALC: begin
        if (cnt_q == 4'd0) begin
          state_d     = DONE;
          reuse_p_d   = prod_fixed;
          reuse_vld_d = 1'b1;
          rsp_data_d  = (op_q == MUL_OP_MUL) ? prod_fixed[XLEN-1:0] : prod_fixed[2*XLEN-1:XLEN];
          rsp_tag_d   = tag_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d     = IDLE;
      cnt_d       = 4'd0;
      reuse_vld_d = 1'b0;
    end
  end

  // State, operand, reuse-entry and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      op_q        <= 2'b00;
      tag_q       <= '0;
      neg_q       <= 1'b0;
      a_mag_q     <= '0;
      b_mag_q     <= '0;
      last_a_q    <= '0;
      last_b_q    <= '0;
      last_cls_q  <= '0;
      reuse_p_q   <= '0;
      reuse_vld_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
      neg_q       <= neg_d;
      a_mag_q     <= a_mag_d;
      b_mag_q     <= b_mag_d;
      last_a_q    <= last_a_d;
      last_b_q    <= last_b_d;
      last_cls_q  <= last_cls_d;
      reuse_p_q   <= reuse_p_d;
      reuse_vld_q <= reuse_vld_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: cycle-level behavioural model with a per-cycle compare process,
// directed cases with hand-computed results, then randomized traffic with flushes.
module tb_mul_seq_ctrl;

  localparam int MUL_CYCLES = 2;
  localparam int TAG_W      = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = 2'b00;
  logic [31:0]      req_a = '0;
  logic [31:0]      req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;

  mul_seq_ctrl #(.MUL_CYCLES(MUL_CYCLES), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    n_cmp++;
    n_bad++;
    $display("[TB] FAIL %s: timed out waiting on DUT", name);
  endtask

  // Sign class as {a_signed, b_signed}; MUL behaves like MULHU
  function automatic logic [1:0] clsOf(input logic [1:0] op);
    return {(op == 2'b01) || (op == 2'b10), op == 2'b01};
  endfunction

  // Architectural RV32M result from plain 64-bit arithmetic
  function automatic logic [31:0] refResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = ((op == 2'b01) || (op == 2'b10)) ? longint'($signed(a)) : longint'({32'b0, a});
    sb = (op == 2'b01) ? longint'($signed(b)) : longint'({32'b0, b});
    p = 64'(sa * sb);
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Behavioural model: phase 0 idle, 1 waiting, 2 response pending
  int               m_phase = 0;
  int               m_left = 0;
  logic [31:0]      m_data = '0;
  logic [TAG_W-1:0] m_tag = '0;
  bit               r_vld = 0;
  logic [31:0]      r_a = '0, r_b = '0, p_a = '0, p_b = '0;
  logic [1:0]       r_cls = '0, p_cls = '0;

  // Model advances on every clock edge from the same inputs the DUT sees
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_left  <= 0;
      r_vld   <= 0;
      m_data  <= '0;
      m_tag   <= '0;
    end else if (flush) begin
      m_phase <= 0;
      r_vld   <= 0;
    end else begin
      case (m_phase)
        0: if (req_valid) begin
          m_data <= refResult(req_op, req_a, req_b);
          m_tag  <= req_tag;
          if (r_vld && req_a == r_a && req_b == r_b && (req_op == 2'b00 || clsOf(req_op) == r_cls)) begin
            m_phase <= 2;
          end else begin
            m_phase <= 1;
            m_left  <= MUL_CYCLES;
            p_a     <= req_a;
            p_b     <= req_b;
            p_cls   <= clsOf(req_op);
          end
        end
        1: begin
          if (m_left == 1) begin
            m_phase <= 2;
            r_vld   <= 1;
            r_a     <= p_a;
            r_b     <= p_b;
            r_cls   <= p_cls;
          end
          m_left <= m_left - 1;
        end
        default: if (rsp_ready) m_phase <= 0;
      endcase
    end
  end

  // Per-cycle comparison of DUT outputs against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      checkOutput("rst_busy", 64'(busy), 64'(0));
      checkOutput("rst_req_ready", 64'(req_ready), 64'(0));
      checkOutput("rst_rsp_data", 64'(rsp_data), 64'(0));
      checkOutput("rst_rsp_tag", 64'(rsp_tag), 64'(0));
    end else begin
      checkOutput("cyc_rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
      checkOutput("cyc_busy", 64'(busy), 64'(m_phase != 0));
      checkOutput("cyc_req_ready", 64'(req_ready), 64'((m_phase == 0) && !flush));
      if (m_phase == 2) begin
        checkOutput("cyc_rsp_data", 64'(rsp_data), 64'(m_data));
        checkOutput("cyc_rsp_tag", 64'(rsp_tag), 64'(m_tag));
      end
    end
  end

  // Called at negedge+1 with a request driven; returns once it is accepted at the coming edge
  task automatic waitAccept(output bit ok);
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      #2;
      if (req_ready) ok = 1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    if (!ok) reportTimeout("accept");
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [TAG_W-1:0] tag, input int hold, input int expLat,
                               output logic [31:0] data);
    bit ok;
    int lat;
    logic [31:0] d0;
    logic [TAG_W-1:0] t0;
    data = '0;
    @(negedge clk);
    #1;
    req_valid = 1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    rsp_ready = (hold == 0);
    waitAccept(ok);
    if (!ok) begin
      req_valid = 0;
      return;
    end
    @(negedge clk);
    #1;
    req_valid = 0;
    req_a     = $urandom;
    req_b     = $urandom;
    req_op    = 2'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      #1;
      lat++;
    end
    if (!rsp_valid) begin
      reportTimeout("rsp_valid");
      rsp_ready = 0;
      return;
    end
    if (expLat >= 0) checkOutput("latency", 64'(lat), 64'(expLat));
    data = rsp_data;
    d0   = rsp_data;
    t0   = rsp_tag;
    checkOutput("rsp_tag_ret", 64'(rsp_tag), 64'(tag));
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        #1;
      end
      checkOutput("hold_valid", 64'(rsp_valid), 64'(1));
      checkOutput("hold_data", 64'(rsp_data), 64'(d0));
      checkOutput("hold_tag", 64'(rsp_tag), 64'(t0));
      checkOutput("hold_req_ready", 64'(req_ready), 64'(0));
      checkOutput("hold_busy", 64'(busy), 64'(1));
      rsp_ready = 1;
      @(negedge clk);
      #1;
      rsp_ready = 0;
    end else begin
      @(negedge clk);
      #1;
      rsp_ready = 0;
    end
    checkOutput("post_busy", 64'(busy), 64'(0));
    checkOutput("post_req_ready", 64'(req_ready), 64'(1));
  endtask

  // Accept an op, wait 'after' cycles, then flush while also presenting a request
  task automatic flushDuring(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [TAG_W-1:0] tag, input int after);
    bit ok;
    @(negedge clk);
    #1;
    req_valid = 1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    rsp_ready = 0;
    waitAccept(ok);
    if (!ok) begin
      req_valid = 0;
      return;
    end
    @(negedge clk);
    #1;
    req_valid = 0;
    repeat (after) begin
      @(negedge clk);
      #1;
    end
    flush     = 1;
    req_valid = 1;
    @(negedge clk);
    #1;
    flush     = 0;
    req_valid = 0;
    checkOutput("flush_busy", 64'(busy), 64'(0));
    checkOutput("flush_rsp_valid", 64'(rsp_valid), 64'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  op;
    logic [31:0] a, b;
    bit ok;
    int w;

    repeat (2) @(negedge clk);
    #1;
    rst_n = 1;

    // 1: basic MUL, full latency
    applyStimulus(2'b00, 32'd7, 32'd6, 5'd3, 0, MUL_CYCLES + 1, d);
    checkOutput("t1_mul", 64'(d), 64'h2A);
    // 2: signed high half, then same operands in another class misses
    applyStimulus(2'b01, 32'hFFFFFFFF, 32'd2, 5'd4, 0, MUL_CYCLES + 1, d);
    checkOutput("t2_mulh", 64'(d), 64'hFFFFFFFF);
    applyStimulus(2'b11, 32'hFFFFFFFF, 32'd2, 5'd5, 0, MUL_CYCLES + 1, d);
    checkOutput("t2_mulhu", 64'(d), 64'h1);
    // 3: most-negative operand corners
    applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd6, 0, MUL_CYCLES + 1, d);
    checkOutput("t3_mulhsu", 64'(d), 64'h80000000);
    applyStimulus(2'b01, 32'h80000000, 32'h80000000, 5'd7, 0, MUL_CYCLES + 1, d);
    checkOutput("t3_mulh_min", 64'(d), 64'h40000000);
    // 4: MUL after MULH with same operands hits the reuse entry
    applyStimulus(2'b01, 32'h12345678, 32'h9ABCDEF0, 5'd8, 0, MUL_CYCLES + 1, d);
    applyStimulus(2'b00, 32'h12345678, 32'h9ABCDEF0, 5'd9, 0, 1, d);
    checkOutput("t4_mul_hit", 64'(d), 64'h242D2080);
    // 5: backpressure
    applyStimulus(2'b00, 32'd3, 32'd5, 5'd10, 5, MUL_CYCLES + 1, d);
    checkOutput("t5_mul", 64'(d), 64'd15);
    // 6: flush in first CALC cycle kills the op and the reuse entry
    flushDuring(2'b01, 32'h12345678, 32'h9ABCDEF0, 5'd11, 0);
    applyStimulus(2'b00, 32'h12345678, 32'h9ABCDEF0, 5'd12, 0, MUL_CYCLES + 1, d);
    checkOutput("t6_after_flush", 64'(d), 64'h242D2080);

    // 6b: asynchronous reset while a response is pending
    @(negedge clk);
    #1;
    req_valid = 1;
    req_op    = 2'b00;
    req_a     = 32'd9;
    req_b     = 32'd9;
    req_tag   = 5'd13;
    rsp_ready = 0;
    waitAccept(ok);
    @(negedge clk);
    #1;
    req_valid = 0;
    w = 0;
    while (!rsp_valid && w < 40) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (!rsp_valid) reportTimeout("t6b_valid");
    #1;
    rst_n = 0;
    #1;
    checkOutput("t6b_async_valid", 64'(rsp_valid), 64'(0));
    checkOutput("t6b_async_busy", 64'(busy), 64'(0));
    @(negedge clk);
    #1;
    rst_n = 1;

    // Randomized traffic with a small operand pool to provoke reuse hits
    a = 32'd1;
    b = 32'd1;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 3))
          0: a = 32'h80000000;
          1: a = 32'hFFFFFFFF;
          2: a = 32'($urandom_range(0, 15));
          default: a = $urandom;
        endcase
        case ($urandom_range(0, 3))
          0: b = 32'h80000000;
          1: b = 32'hFFFFFFFF;
          2: b = 32'($urandom_range(0, 15));
          default: b = $urandom;
        endcase
      end
      if ($urandom_range(0, 7) == 0)
        flushDuring(op, a, b, 5'($urandom), $urandom_range(0, 4));
      else begin
        applyStimulus(op, a, b, 5'($urandom), $urandom_range(0, 3), -1, d);
        checkOutput("rnd_data", 64'(d), 64'(refResult(op, a, b)));
      end
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
